bus_term_fifo_bank: RTL and testbench

Parametrised bank of per-terminal FIFO pairs sitting between the verification/agent side and the bus arbiter `bs_gnrtr_n_rbtr`. Each terminal gets a transmit FIFO that drives the arbiter's `pndng`/`D_pop`/`pop` handshake and a receive FIFO that captures `push`/`D_push`. It generalises the single-bus, fixed-4-terminal arrangement to `bits` buses × `drvrs` terminals. It adds configurable depth, a selectable receive-overflow policy, and per-terminal drop and error accounting.

---
 rtl/bus_term_pkg.sv | 20 ++
 rtl/bus_term_fifo_bank_fifo.sv | 82 ++++++++
 rtl/bus_term_fifo_bank.sv | 98 +++++++++
 tb/tb_bus_term_fifo_bank.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_term_pkg.sv
// Shared constants and helpers for the per-terminal FIFO bank.
package bus_term_pkg;

  localparam int unsigned OVF_DROP_NEW  = 0;
  localparam int unsigned OVF_OVERWRITE = 1;

  localparam int unsigned DROP_CNT_W = 8;
  localparam int unsigned PCKG_SZ    = 16;

  typedef logic [PCKG_SZ-1:0]    pckt_t;
  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  // A terminal can lose one transmit and one receive packet in the same cycle.
  function automatic drop_cnt_t sat_add(input drop_cnt_t cnt, input logic [1:0] inc);
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_CNT_W-1){1'b0}}, inc};
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/bus_term_fifo_bank_fifo.sv
// Single-clock show-ahead FIFO; a read and a write in the same cycle on a
// full FIFO always succeed, and the overflow mode picks which packet is lost.
module bus_sync_fifo
  import bus_term_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned OVF_MODE = OVF_DROP_NEW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   rd_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   drop_o,
  output logic                   underflow_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam bit          OVERWRITE = (OVF_MODE == OVF_OVERWRITE);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             rd_ok, do_wr, do_rd;

  // In overwrite mode a write into a full FIFO retires the oldest entry.
  always_comb begin
    rd_ok    = rd_i && !empty_q;
    do_wr    = wr_i && (!full_q || rd_ok || OVERWRITE);
    do_rd    = rd_ok || (wr_i && full_q && OVERWRITE);
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CW'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_wr) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Stale storage is hidden so an empty FIFO always presents zero.
  assign head_o      = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign drop_o      = wr_i && full_q && !rd_ok;
  assign underflow_o = rd_i && empty_q;

endmodule

// File: rtl/bus_term_fifo_bank.sv
// Bank of transmit/receive FIFO pairs, one pair per terminal per bus, with
// saturating lost-packet counters and sticky protocol-error flags.
module bus_term_fifo_bank
  import bus_term_pkg::*;
#(
  parameter int unsigned bits     = 1,
  parameter int unsigned drvrs    = 4,
  parameter int unsigned pckg_sz  = 16,
  parameter int unsigned depth    = 8,
  parameter int unsigned ovf_mode = OVF_DROP_NEW
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [bits-1:0][drvrs-1:0]                           tx_wr,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]              tx_data,
  output logic [bits-1:0][drvrs-1:0]                           tx_full,
  output logic [bits-1:0][drvrs-1:0]                           pndng,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]              D_pop,
  input  logic [bits-1:0][drvrs-1:0]                           pop,
  input  logic [bits-1:0][drvrs-1:0]                           push,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]              D_push,
  input  logic [bits-1:0][drvrs-1:0]                           rx_rd,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]              rx_data,
  output logic [bits-1:0][drvrs-1:0]                           rx_empty,
  output logic [bits-1:0][drvrs-1:0][$clog2(depth):0]          rx_count,
  output logic [bits-1:0][drvrs-1:0][DROP_CNT_W-1:0]           drop_cnt,
  output logic [bits-1:0][drvrs-1:0]                           err
);

  for (genvar b = 0; b < bits; b++) begin : g_bus
    for (genvar d = 0; d < drvrs; d++) begin : g_term
      logic                    tx_empty;
      logic                    tx_drop, rx_drop;
      logic                    tx_unf, rx_unf;
      logic [$clog2(depth):0]  tx_count_unused;
      logic                    rx_full_unused;
      logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
      logic                    err_q, err_d;

      // The transmit side never overwrites: the agent is throttled by tx_full.
      bus_sync_fifo #(
        .DEPTH    (depth),
        .WIDTH    (pckg_sz),
        .OVF_MODE (OVF_DROP_NEW)
      ) u_tx (
        .clk         (clk),
        .reset       (reset),
        .wr_i        (tx_wr[b][d]),
        .wdata_i     (tx_data[b][d]),
        .rd_i        (pop[b][d]),
        .head_o      (D_pop[b][d]),
        .full_o      (tx_full[b][d]),
        .empty_o     (tx_empty),
        .count_o     (tx_count_unused),
        .drop_o      (tx_drop),
        .underflow_o (tx_unf)
      );

      bus_sync_fifo #(
        .DEPTH    (depth),
        .WIDTH    (pckg_sz),
        .OVF_MODE (ovf_mode)
      ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .wr_i        (push[b][d]),
        .wdata_i     (D_push[b][d]),
        .rd_i        (rx_rd[b][d]),
        .head_o      (rx_data[b][d]),
        .full_o      (rx_full_unused),
        .empty_o     (rx_empty[b][d]),
        .count_o     (rx_count[b][d]),
        .drop_o      (rx_drop),
        .underflow_o (rx_unf)
      );

      always_comb begin
        drop_cnt_d = sat_add(drop_cnt_q, {1'b0, tx_drop} + {1'b0, rx_drop});
        err_d      = err_q | tx_unf | rx_unf;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          drop_cnt_q <= '0;
          err_q      <= 1'b0;
        end else begin
          drop_cnt_q <= drop_cnt_d;
          err_q      <= err_d;
        end
      end

      assign pndng[b][d]    = !tx_empty;
      assign drop_cnt[b][d] = drop_cnt_q;
      assign err[b][d]      = err_q;
    end
  end

endmodule

// File: tb/tb_bus_term_fifo_bank.sv
// Bench: two banks (drop-new and overwrite receive policy) share all inputs;
// directed scenarios plus a randomized run against a queue-based model.
module tb_bus_term_fifo_bank;

  localparam int B   = 2;
  localparam int D   = 4;
  localparam int W   = 16;
  localparam int DEP = 8;
  localparam int CW  = $clog2(DEP) + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [B-1:0][D-1:0]        tx_wr, pop, push, rx_rd;
  logic [B-1:0][D-1:0][W-1:0] tx_data, D_push;

  logic [B-1:0][D-1:0]         tx_full_o  [2];
  logic [B-1:0][D-1:0]         pndng_o    [2];
  logic [B-1:0][D-1:0]         rx_empty_o [2];
  logic [B-1:0][D-1:0]         err_o      [2];
  logic [B-1:0][D-1:0][W-1:0]  D_pop_o    [2];
  logic [B-1:0][D-1:0][W-1:0]  rx_data_o  [2];
  logic [B-1:0][D-1:0][CW-1:0] rx_count_o [2];
  logic [B-1:0][D-1:0][7:0]    drop_cnt_o [2];

  int nChecks = 0;
  int nPass   = 0;

  // Reference model: index 0 is the drop-new bank, index 1 the overwrite bank.
  logic [W-1:0] mtx [B][D][$];
  logic [W-1:0] mrx [2][B][D][$];
  int           mdrop [2][B][D];
  bit           merr  [2][B][D];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    bus_term_fifo_bank #(
      .bits     (B),
      .drvrs    (D),
      .pckg_sz  (W),
      .depth    (DEP),
      .ovf_mode (gi)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .tx_wr    (tx_wr),
      .tx_data  (tx_data),
      .tx_full  (tx_full_o[gi]),
      .pndng    (pndng_o[gi]),
      .D_pop    (D_pop_o[gi]),
      .pop      (pop),
      .push     (push),
      .D_push   (D_push),
      .rx_rd    (rx_rd),
      .rx_data  (rx_data_o[gi]),
      .rx_empty (rx_empty_o[gi]),
      .rx_count (rx_count_o[gi]),
      .drop_cnt (drop_cnt_o[gi]),
      .err      (err_o[gi])
    );
  end

  task automatic clear_inputs();
    tx_wr   = '0;
    pop     = '0;
    push    = '0;
    rx_rd   = '0;
    tx_data = '0;
    D_push  = '0;
  endtask

  // Applies the current inputs to the model exactly as one clock edge would.
  task automatic model_step();
    for (int b = 0; b < B; b++) begin
      for (int d = 0; d < D; d++) begin
        int txDrop;
        bit txErr;
        txDrop = 0;
        txErr  = 0;
        if (reset) begin
          mtx[b][d].delete();
          for (int i = 0; i < 2; i++) begin
            mrx[i][b][d].delete();
            mdrop[i][b][d] = 0;
            merr[i][b][d]  = 0;
          end
        end else begin
          if (pop[b][d]) begin
            if (mtx[b][d].size() > 0) void'(mtx[b][d].pop_front());
            else txErr = 1;
          end
          if (tx_wr[b][d]) begin
            if (mtx[b][d].size() < DEP) mtx[b][d].push_back(tx_data[b][d]);
            else txDrop = 1;
          end
          for (int i = 0; i < 2; i++) begin
            int drops;
            drops = txDrop;
            if (txErr) merr[i][b][d] = 1;
            if (rx_rd[b][d]) begin
              if (mrx[i][b][d].size() > 0) void'(mrx[i][b][d].pop_front());
              else merr[i][b][d] = 1;
            end
            if (push[b][d]) begin
              if (mrx[i][b][d].size() < DEP) begin
                mrx[i][b][d].push_back(D_push[b][d]);
              end else begin
                drops++;
                if (i == 1) begin
                  void'(mrx[i][b][d].pop_front());
                  mrx[i][b][d].push_back(D_push[b][d]);
                end
              end
            end
            mdrop[i][b][d] = (mdrop[i][b][d] + drops > 255) ? 255 : mdrop[i][b][d] + drops;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (pndng_o[i] !== '0) $display("[TB] FAIL reset_pndng[%0d]: got %h expected 0", i, pndng_o[i]); else nPass++;
      nChecks++; if (tx_full_o[i] !== '0) $display("[TB] FAIL reset_tx_full[%0d]: got %h expected 0", i, tx_full_o[i]); else nPass++;
      nChecks++; if (rx_empty_o[i] !== '1) $display("[TB] FAIL reset_rx_empty[%0d]: got %h expected ff", i, rx_empty_o[i]); else nPass++;
      nChecks++; if (rx_count_o[i] !== '0) $display("[TB] FAIL reset_rx_count[%0d]: got %h expected 0", i, rx_count_o[i]); else nPass++;
      nChecks++; if (drop_cnt_o[i] !== '0) $display("[TB] FAIL reset_drop_cnt[%0d]: got %h expected 0", i, drop_cnt_o[i]); else nPass++;
      nChecks++; if (err_o[i] !== '0) $display("[TB] FAIL reset_err[%0d]: got %h expected 0", i, err_o[i]); else nPass++;
      nChecks++; if (D_pop_o[i] !== '0) $display("[TB] FAIL reset_D_pop[%0d]: got %h expected 0", i, D_pop_o[i]); else nPass++;
      nChecks++; if (rx_data_o[i] !== '0) $display("[TB] FAIL reset_rx_data[%0d]: got %h expected 0", i, rx_data_o[i]); else nPass++;
    end
  endtask

  task automatic test_basic_write();
    do_reset();
    tx_wr[0][2]   = 1'b1;
    tx_data[0][2] = 16'h1234;
    tick();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (pndng_o[i] !== 8'h04) $display("[TB] FAIL basic_pndng[%0d]: got %h expected 04", i, pndng_o[i]); else nPass++;
      nChecks++; if (D_pop_o[i][0][2] !== 16'h1234) $display("[TB] FAIL basic_D_pop[%0d]: got %h expected 1234", i, D_pop_o[i][0][2]); else nPass++;
    end
    pop[0][2] = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (pndng_o[i][0][2] !== 1'b0) $display("[TB] FAIL basic_pndng_after_pop[%0d]: got %b expected 0", i, pndng_o[i][0][2]); else nPass++;
      nChecks++; if (err_o[i] !== '0) $display("[TB] FAIL basic_err[%0d]: got %h expected 0", i, err_o[i]); else nPass++;
    end
  endtask

  task automatic test_tx_overflow();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      tx_wr[1][1]   = 1'b1;
      tx_data[1][1] = W'(k);
      tick();
      if (k == 6 || k == 7) begin
        nChecks++;
        if (tx_full_o[0][1][1] !== (k == 7))
          $display("[TB] FAIL txovf_full_after_%0d: got %b expected %b", k + 1, tx_full_o[0][1][1], (k == 7));
        else nPass++;
      end
    end
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (drop_cnt_o[i][1][1] !== 8'd1) $display("[TB] FAIL txovf_drop[%0d]: got %0d expected 1", i, drop_cnt_o[i][1][1]); else nPass++;
    end
    for (int k = 0; k < 8; k++) begin
      nChecks++;
      if (D_pop_o[0][1][1] !== W'(k) || pndng_o[0][1][1] !== 1'b1)
        $display("[TB] FAIL txovf_pop_%0d: got head %h pndng %b expected head %h pndng 1", k, D_pop_o[0][1][1], pndng_o[0][1][1], W'(k));
      else nPass++;
      pop[1][1] = 1'b1;
      tick();
      clear_inputs();
    end
    nChecks++; if (pndng_o[0][1][1] !== 1'b0 || tx_full_o[0][1][1] !== 1'b0) $display("[TB] FAIL txovf_drained: got pndng %b full %b expected 0 0", pndng_o[0][1][1], tx_full_o[0][1][1]); else nPass++;
    nChecks++; if (err_o[0] !== '0) $display("[TB] FAIL txovf_err: got %h expected 0", err_o[0]); else nPass++;
  endtask

  task automatic test_rx_overflow();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      push[0][0]   = 1'b1;
      D_push[0][0] = W'(16'hA0 + k);
      tick();
    end
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (rx_count_o[i][0][0] !== CW'(8)) $display("[TB] FAIL rxovf_count[%0d]: got %0d expected 8", i, rx_count_o[i][0][0]); else nPass++;
      nChecks++; if (drop_cnt_o[i][0][0] !== 8'd2) $display("[TB] FAIL rxovf_drop[%0d]: got %0d expected 2", i, drop_cnt_o[i][0][0]); else nPass++;
    end
    for (int k = 0; k < 8; k++) begin
      nChecks++; if (rx_data_o[0][0][0] !== W'(16'hA0 + k)) $display("[TB] FAIL rxovf_dropnew_read_%0d: got %h expected %h", k, rx_data_o[0][0][0], W'(16'hA0 + k)); else nPass++;
      nChecks++; if (rx_data_o[1][0][0] !== W'(16'hA2 + k)) $display("[TB] FAIL rxovf_overwrite_read_%0d: got %h expected %h", k, rx_data_o[1][0][0], W'(16'hA2 + k)); else nPass++;
      rx_rd[0][0] = 1'b1;
      tick();
      clear_inputs();
    end
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (rx_empty_o[i][0][0] !== 1'b1 || rx_count_o[i][0][0] !== '0) $display("[TB] FAIL rxovf_drained[%0d]: got empty %b count %0d expected 1 0", i, rx_empty_o[i][0][0], rx_count_o[i][0][0]); else nPass++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      push[0][1]   = 1'b1;
      D_push[0][1] = W'(16'h10 + k);
      tick();
    end
    push[0][1]   = 1'b1;
    D_push[0][1] = 16'h0055;
    rx_rd[0][1]  = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (rx_count_o[i][0][1] !== CW'(8)) $display("[TB] FAIL simul_count[%0d]: got %0d expected 8", i, rx_count_o[i][0][1]); else nPass++;
      nChecks++; if (drop_cnt_o[i][0][1] !== 8'd0) $display("[TB] FAIL simul_drop[%0d]: got %0d expected 0", i, drop_cnt_o[i][0][1]); else nPass++;
      nChecks++; if (rx_data_o[i][0][1] !== 16'h0011) $display("[TB] FAIL simul_head[%0d]: got %h expected 0011", i, rx_data_o[i][0][1]); else nPass++;
    end
    pop[1][3] = 1'b1;
    tick();
    clear_inputs();
    nChecks++; if (err_o[0] !== 8'h80) $display("[TB] FAIL err_pop_empty: got %h expected 80", err_o[0]); else nPass++;
    repeat (5) tick();
    nChecks++; if (err_o[1][1][3] !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", err_o[1][1][3]); else nPass++;
    rx_rd[1][2] = 1'b1;
    tick();
    clear_inputs();
    nChecks++; if (err_o[0] !== 8'hC0) $display("[TB] FAIL err_rd_empty: got %h expected c0", err_o[0]); else nPass++;
    do_reset();
    nChecks++; if (err_o[0] !== '0 || err_o[1] !== '0) $display("[TB] FAIL err_cleared: got %h/%h expected 0/0", err_o[0], err_o[1]); else nPass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tx_wr[0][3]   = 1'b1;
      tx_data[0][3] = W'(16'hC0 + k);
      push[0][3]    = 1'b1;
      D_push[0][3]  = W'(16'hD0 + k);
      pop[1][0]     = 1'b1;
      tick();
    end
    clear_inputs();
    nChecks++; if (pndng_o[0][0][3] !== 1'b1 || rx_count_o[0][0][3] !== CW'(3) || err_o[0][1][0] !== 1'b1) $display("[TB] FAIL midrst_before: got pndng %b count %0d err %b expected 1 3 1", pndng_o[0][0][3], rx_count_o[0][0][3], err_o[0][1][0]); else nPass++;
    reset         = 1'b1;
    tx_wr[0][3]   = 1'b1;
    tx_data[0][3] = 16'hBEEF;
    push[0][3]    = 1'b1;
    D_push[0][3]  = 16'hCAFE;
    pop[1][1]     = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (pndng_o[i] !== '0 || D_pop_o[i] !== '0) $display("[TB] FAIL midrst_tx[%0d]: got pndng %h D_pop %h expected 0 0", i, pndng_o[i], D_pop_o[i]); else nPass++;
      nChecks++; if (rx_empty_o[i] !== '1 || rx_count_o[i] !== '0 || rx_data_o[i] !== '0) $display("[TB] FAIL midrst_rx[%0d]: got empty %h count %h data %h expected ff 0 0", i, rx_empty_o[i], rx_count_o[i], rx_data_o[i]); else nPass++;
      nChecks++; if (drop_cnt_o[i] !== '0 || err_o[i] !== '0) $display("[TB] FAIL midrst_cnt[%0d]: got drop %h err %h expected 0 0", i, drop_cnt_o[i], err_o[i]); else nPass++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 308; k++) begin
      tx_wr[1][0]   = 1'b1;
      tx_data[1][0] = W'(k);
      tick();
      if (k == 261) begin
        nChecks++; if (drop_cnt_o[0][1][0] !== 8'd254) $display("[TB] FAIL sat_before: got %0d expected 254", drop_cnt_o[0][1][0]); else nPass++;
      end
    end
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (drop_cnt_o[i][1][0] !== 8'd255) $display("[TB] FAIL sat_drop[%0d]: got %0d expected 255", i, drop_cnt_o[i][1][0]); else nPass++;
      for (int b = 0; b < B; b++) begin
        for (int d = 0; d < D; d++) begin
          if (!(b == 1 && d == 0)) begin
            nChecks++;
            if (drop_cnt_o[i][b][d] !== 8'd0 || pndng_o[i][b][d] !== 1'b0)
              $display("[TB] FAIL sat_isolation[%0d][%0d][%0d]: got drop %0d pndng %b expected 0 0", i, b, d, drop_cnt_o[i][b][d], pndng_o[i][b][d]);
            else nPass++;
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [47:0] got, exp;
    logic [W-1:0] expHead, expRx;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int b = 0; b < B; b++) begin
        for (int d = 0; d < D; d++) begin
          tx_wr[b][d]   = 1'($urandom_range(0, 1));
          tx_data[b][d] = W'($urandom);
          pop[b][d]     = ($urandom_range(0, 2) == 0);
          push[b][d]    = 1'($urandom_range(0, 1));
          D_push[b][d]  = W'($urandom);
          rx_rd[b][d]   = ($urandom_range(0, 2) == 0);
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        for (int b = 0; b < B; b++) begin
          for (int d = 0; d < D; d++) begin
            expHead = (mtx[b][d].size() > 0) ? mtx[b][d][0] : '0;
            expRx   = (mrx[i][b][d].size() > 0) ? mrx[i][b][d][0] : '0;
            exp = {mtx[b][d].size() != 0, mtx[b][d].size() == DEP, mrx[i][b][d].size() == 0,
                   merr[i][b][d], CW'(mrx[i][b][d].size()), 8'(mdrop[i][b][d]), expHead, expRx};
            got = {pndng_o[i][b][d], tx_full_o[i][b][d], rx_empty_o[i][b][d], err_o[i][b][d],
                   rx_count_o[i][b][d], drop_cnt_o[i][b][d], D_pop_o[i][b][d], rx_data_o[i][b][d]};
            nChecks++;
            if (got !== exp)
              $display("[TB] FAIL random_c%0d[%0d][%0d][%0d]: got %h expected %h (pndng,full,empty,err,count,drop,head,rx)", c, i, b, d, got, exp);
            else nPass++;
          end
        end
      end
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic_write();
    test_tx_overflow();
    test_rx_overflow();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
